// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and widths for the ALU long-latency units
package alu_pkg;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/shift_step_1b.sv
// shift_step_1b: one combinational 1-bit shift/rotate stage
import alu_pkg::*;
module shift_step_1b #(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] din,
    input  logic [1:0]   op,
    output logic [W-1:0] dout
);
    always_comb
        dout = (op == OP_SLL) ? {din[W-2:0], 1'b0} :
               (op == OP_SRL) ? {1'b0, din[W-1:1]} :
               (op == OP_SRA) ? {din[W-1], din[W-1:1]} :
                                {din[W-2:0], din[W-1]};
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multicycle shifter applying one 1-bit step per cycle with start/ready handshake
import alu_pkg::*;
module shift_seq_ctrl #(
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic               ctrl_flush,
    input  logic [1:0]         ctrl_op,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);
    state_t             state, state_nx;
    logic [WIDTH-1:0]   work, work_step;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] count;
    logic               start, stepping;
    shift_step_1b #(.W(WIDTH)) u_step (
        .din  (work),
        .op   (op_q),
        .dout (work_step)
    );
    // flush wins over a simultaneous start and freezes the work register
    always_comb begin
        start    = ctrl_shift && !ctrl_flush && (state == S_IDLE || state == S_DONE);
        stepping = (state == S_SHIFT) && !ctrl_flush;
        state_nx = ctrl_flush ? S_IDLE :
                   start ? ((ctrl_shiftamt != '0) ? S_SHIFT : S_DONE) :
                   (state == S_SHIFT) ? ((count == SHAMT_W'(1)) ? S_DONE : S_SHIFT) :
                   S_IDLE;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            work  <= '0;
            op_q  <= OP_SLL;
            count <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                work  <= data_operandA;
                op_q  <= ctrl_op;
                count <= ctrl_shiftamt;
            end else if (stepping) begin
                work  <= work_step;
                count <= count - SHAMT_W'(1);
            end
        end
    end
    assign busy           = (state == S_SHIFT);
    assign data_resultRDY = (state == S_DONE);
    assign data_result    = work;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed scoreboard bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
    logic        clock = 0, reset = 0, ctrl_shift = 0, ctrl_flush = 0;
    logic [1:0]  ctrl_op = 0;
    logic [4:0]  ctrl_shiftamt = 0;
    logic [31:0] data_operandA = 0, data_result;
    logic        data_resultRDY, busy;
    typedef struct {logic [31:0] res; int cyc;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0, busy_cycles = 0, rdy_cnt = 0;
    shift_seq_ctrl dut (
        .clock(clock), .reset(reset), .ctrl_shift(ctrl_shift), .ctrl_flush(ctrl_flush),
        .ctrl_op(ctrl_op), .ctrl_shiftamt(ctrl_shiftamt), .data_operandA(data_operandA),
        .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask
    task automatic tick();
        exp_t e;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (busy) busy_cycles++;
        if (data_resultRDY) begin
            rdy_cnt++;
            if (q.size() == 0) check("spurious_rdy", 32'(data_resultRDY), 0);
            else begin
                e = q.pop_front();
                check("result", data_result, e.res);
                check("rdy_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask
    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt, input logic [31:0] res);
        ctrl_shift = 1; ctrl_op = op; data_operandA = a; ctrl_shiftamt = amt;
        q.push_back('{res, cyc + int'(amt) + 1});
        tick();
        ctrl_shift = 0; data_operandA = 32'hA5A5_5A5A; ctrl_shiftamt = 5'd7;
    endtask
    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin tick(); n++; end
        check({tag, "_timeout"}, q.size(), 0);
    endtask
    initial begin
        repeat (2) @(negedge clock);
        check("rst_result", data_result, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy", 32'(data_resultRDY), 0);
        reset = 1;
        tick();
        busy_cycles = 0; rdy_cnt = 0;
        start(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        wait_done("sll31", 40);
        check("sll31_busy_cycles", 32'(busy_cycles), 31);
        check("sll31_rdy_count", 32'(rdy_cnt), 1);
        start(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
        wait_done("sra4", 10);
        start(2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000);
        wait_done("srl4", 10);
        start(2'b11, 32'h8000_0001, 5'd1, 32'h0000_0003);
        wait_done("rotl1", 10);
        start(2'b11, 32'h0F00_00F0, 5'd8, 32'h0000_F00F);
        wait_done("rotl8", 15);
        repeat (2) tick();
        busy_cycles = 0;
        start(2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        wait_done("shamt0", 5);
        check("shamt0_busy_cycles", 32'(busy_cycles), 0);
        tick();
        check("done_to_idle_rdy", 32'(data_resultRDY), 0);
        start(2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400);
        tick(); tick();
        ctrl_flush = 1; ctrl_shift = 1; data_operandA = 32'h1111_1111; ctrl_shiftamt = 5'd3;
        q.delete();
        tick();
        ctrl_flush = 0; ctrl_shift = 0;
        check("flush_busy", 32'(busy), 0);
        check("flush_work_kept", data_result, 32'h0000_0004);
        rdy_cnt = 0;
        repeat (15) tick();
        check("flush_no_rdy", 32'(rdy_cnt), 0);
        start(2'b10, 32'h0000_8000, 5'd3, 32'h0000_1000);
        wait_done("after_flush", 10);
        start(2'b00, 32'h0000_1234, 5'd20, 32'h2340_0000);
        repeat (6) tick();
        #2 reset = 0;
        #1;
        check("async_rst_result", data_result, 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_rdy", 32'(data_resultRDY), 0);
        q.delete();
        @(negedge clock);
        tick();
        reset = 1;
        rdy_cnt = 0; busy_cycles = 0;
        repeat (25) tick();
        check("post_rst_no_rdy", 32'(rdy_cnt), 0);
        check("post_rst_no_busy", 32'(busy_cycles), 0);
        start(2'b00, 32'h0000_1234, 5'd20, 32'h2340_0000);
        wait_done("after_rst", 25);
        start(2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004);
        tick(); tick();
        check("b2b_op1_rdy", 32'(data_resultRDY), 1);
        start(2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F);
        wait_done("b2b_op2", 10);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
